// File: rtl/inst_fetch_resp.sv
// inst_fetch_resp: accepts byte-PC fetch requests, reads a synchronous ROM and returns words in order
// through a 2-entry output buffer. Define FETCH_ALIGN_CHECK_EN to flag misaligned PCs via inst_err.
module inst_fetch_resp #(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  output logic                  rom_en,
  output logic [DEPTH_LOG2-1:0] rom_addr,
  input  logic [31:0]           rom_data,
  output logic                  inst_valid,
  output logic [31:0]           inst_data,
  output logic [31:0]           inst_pc,
  output logic                  inst_err,
  input  logic                  inst_ready,
  input  logic                  flush
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             if_vld;
  logic [31:0]      if_pc;
  logic [31:0]      buf_pc   [BUF_DEPTH];
  logic [31:0]      buf_data [BUF_DEPTH];

  logic             misaligned;
  logic             pop;
  logic             push;
  logic             accept;
  logic [31:0]      wr_data;
  logic [OCC_W-1:0] occ;

  assign pop       = inst_valid && inst_ready;
  assign push      = if_vld && !flush;
  // Slots already committed (buffered + in flight) once this cycle's pop is retired.
  assign occ       = OCC_W'(count) + OCC_W'(if_vld) - OCC_W'(pop);
  assign req_ready = !flush && (occ < OCC_W'(BUF_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rom_en    = accept && !misaligned;
  assign rom_addr  = req_addr[DEPTH_LOG2+1:2];

  assign inst_valid = (count != '0);
  assign inst_data  = buf_data[rd_ptr];
  assign inst_pc    = buf_pc[rd_ptr];

`ifdef FETCH_ALIGN_CHECK_EN
  logic if_err;
  logic buf_err [BUF_DEPTH];

  assign misaligned = (req_addr[1:0] != 2'b00);
  assign wr_data    = if_err ? 32'h0000_0000 : rom_data;
  assign inst_err   = buf_err[rd_ptr];

  // Error bit travels alongside the fetch so the faulting slot keeps its place in order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_err <= 1'b0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) buf_err[i] <= 1'b0;
    end else begin
      if_err <= misaligned;
      if (push) buf_err[wr_ptr] <= if_err;
    end
  end
`else
  assign misaligned = 1'b0;
  assign wr_data    = rom_data;
  assign inst_err   = 1'b0;
`endif

  // In-flight stage and buffer bookkeeping; flush drops everything including the in-flight read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_vld <= 1'b0;
      if_pc  <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if_vld <= accept;
      if_pc  <= req_addr;
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Buffer storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        buf_pc[i]   <= '0;
        buf_data[i] <= '0;
      end
    end else if (push) begin
      buf_pc[wr_ptr]   <= if_pc;
      buf_data[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// tb_inst_fetch_resp: randomized and directed checks of inst_fetch_resp against a queue-based
// model of outstanding fetches (2-cycle latency, 2 outstanding slots, in-order delivery).
module tb_inst_fetch_resp;

  localparam int unsigned DL = 6;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic [31:0]   req_addr;
  logic          req_ready;
  logic          rom_en;
  logic [DL-1:0] rom_addr;
  logic [31:0]   rom_data;
  logic          inst_valid;
  logic [31:0]   inst_data;
  logic [31:0]   inst_pc;
  logic          inst_err;
  logic          inst_ready;
  logic          flush;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] rom_mem [1 << DL];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
    int          avail;
  } exp_t;
  exp_t q[$];

  inst_fetch_resp #(.DEPTH_LOG2(DL), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_err(inst_err),
    .inst_ready(inst_ready), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data valid the cycle after rom_en.
  always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

  function automatic logic mis_f(input logic [31:0] a);
    return ALIGN_EN && (a[1:0] != 2'b00);
  endfunction

  // One clock: compare outputs at negedge against the model, then advance the model at posedge.
  task automatic cycle(output logic acc);
    logic        exp_vld, exp_rdy, pp, mis;
    logic [31:0] a;
    int          outstanding;
    exp_t        e;
    @(negedge clk);
    exp_vld     = (q.size() > 0) && (q[0].avail <= cyc);
    pp          = exp_vld && inst_ready;
    outstanding = q.size() - (pp ? 1 : 0);
    exp_rdy     = !flush && (outstanding < 2);
    acc         = req_valid && exp_rdy;
    a           = req_addr;
    mis         = mis_f(a);
    checks++;
    if (req_ready !== exp_rdy) begin
      failures++; $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
    end
    checks++;
    if (inst_valid !== exp_vld) begin
      failures++; $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, exp_vld);
    end
    if (exp_vld) begin
      checks++;
      if (inst_pc !== q[0].pc) begin
        failures++; $display("FAIL inst_pc cyc=%0d got=%h exp=%h", cyc, inst_pc, q[0].pc);
      end
      checks++;
      if (inst_data !== q[0].data) begin
        failures++; $display("FAIL inst_data cyc=%0d got=%h exp=%h", cyc, inst_data, q[0].data);
      end
      checks++;
      if (inst_err !== q[0].err) begin
        failures++; $display("FAIL inst_err cyc=%0d got=%b exp=%b", cyc, inst_err, q[0].err);
      end
    end
    checks++;
    if (rom_en !== (acc && !mis)) begin
      failures++; $display("FAIL rom_en cyc=%0d got=%b exp=%b", cyc, rom_en, acc && !mis);
    end
    if (acc && !mis) begin
      checks++;
      if (rom_addr !== a[DL+1:2]) begin
        failures++; $display("FAIL rom_addr cyc=%0d got=%h exp=%h", cyc, rom_addr, a[DL+1:2]);
      end
    end
    checks++;
    if (dut.push && (dut.count == 2'd2)) begin
      failures++; $display("FAIL push_at_full cyc=%0d got=1 exp=0", cyc);
    end
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (flush) q.delete();
    if (acc) begin
      e.pc    = a;
      e.data  = mis ? 32'h0 : rom_mem[a[DL+1:2]];
      e.err   = mis;
      e.avail = cyc + 2;
      q.push_back(e);
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    req_valid = 1'b0;
    flush     = 1'b0;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; inst_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++;
    if ({inst_valid, inst_err} !== 2'b00 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
      failures++; $display("FAIL reset_outputs got=%b%b %h %h exp=00 0 0", inst_valid, inst_err, inst_data, inst_pc);
    end
    checks++;
    if (req_ready !== 1'b1 || rom_en !== 1'b0) begin
      failures++; $display("FAIL reset_req got=%b%b exp=10", req_ready, rom_en);
    end
    req_valid = 1'b1; req_addr = 32'h0000_000C;
    #1;
    checks++;
    if (rom_en !== 1'b1) begin
      failures++; $display("FAIL reset_rom_en got=%b exp=1", rom_en);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic acc;
    inst_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0000_000C;
    cycle(acc);
    idle(3);
  endtask

  task automatic test_stream();
    logic acc;
    int   drops = 0;
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 32'(i * 4);
      cycle(acc);
      if (!acc) drops++;
    end
    checks++;
    if (drops != 0) begin
      failures++; $display("FAIL stream_accepts got=%0d exp=0 refusals", drops);
    end
    idle(3);
  endtask

  task automatic test_backpressure();
    logic [31:0] addrs [3];
    logic        acc;
    int          idx = 0;
    addrs[0] = 32'h10; addrs[1] = 32'h14; addrs[2] = 32'h18;
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = addrs[idx];
      cycle(acc);
      if (acc && idx < 2) idx++;
    end
    checks++;
    if (idx != 2 || dut.count !== 2'd2) begin
      failures++; $display("FAIL bp_fill got=%0d/%0d exp=2/2", idx, dut.count);
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 10 && idx < 3; i++) begin
      req_valid = 1'b1; req_addr = addrs[idx];
      cycle(acc);
      if (acc) idx++;
    end
    checks++;
    if (idx != 3) begin
      failures++; $display("FAIL bp_resume got=%0d exp=3 accepted", idx);
    end
    idle(4);
  endtask

  task automatic test_flush();
    logic acc;
    inst_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h1C; cycle(acc);
    req_valid = 1'b1; req_addr = 32'h20; cycle(acc);
    req_valid = 1'b0; flush = 1'b1;      cycle(acc);
    flush = 1'b0; inst_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h40; cycle(acc);
    checks++;
    if (!acc) begin
      failures++; $display("FAIL flush_reaccept got=0 exp=1");
    end
    idle(4);
  endtask

  task automatic test_reset_mid();
    logic acc;
    inst_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h50; cycle(acc);
    req_valid = 1'b1; req_addr = 32'h54; cycle(acc);
    idle(2);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst_data !== 32'h0) begin
      failures++; $display("FAIL reset_mid got=%b %h %h exp=0 0 0", inst_valid, inst_pc, inst_data);
    end
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    inst_ready = 1'b1;
    idle(4);
  endtask

  task automatic test_align();
    logic acc;
    inst_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0000_0006;
    cycle(acc);
    idle(3);
  endtask

  task automatic test_random();
    logic acc;
    for (int i = 0; i < 400; i++) begin
      req_valid  = ($urandom % 4) != 0;
      req_addr   = $urandom;
      if (($urandom % 4) != 0) req_addr[1:0] = 2'b00;
      inst_ready = ($urandom % 3) != 0;
      flush      = ($urandom % 20) == 0;
      cycle(acc);
    end
    inst_ready = 1'b1;
    idle(4);
  endtask

  initial begin
    for (int i = 0; i < (1 << DL); i++) rom_mem[i] = $urandom;
    rom_mem[3] = 32'hDEAD_BEEF;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_align();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
